// File: rtl/ex_mem_stage_pkg.sv
// Shared definitions for the EX/MEM boundary: control-bundle bit positions
// and the capture transform applied to every beat entering the stage.
package ex_mem_stage_pkg;

  localparam int CTL_MEMREAD  = 0;
  localparam int CTL_MEMWRITE = 1;
  localparam int CTL_REGWRITE = 2;
  localparam int CTL_MEMTOREG = 3;
  localparam int CTL_BRTAKEN  = 4;
  localparam int CTL_EXC_OVF  = 5;
  localparam int CTL_W        = 6;

  // A trapping overflow squashes every side effect so the exception is precise.
  function automatic logic [CTL_W-1:0] capture_ctl(
    input logic memread,
    input logic memwrite,
    input logic regwrite,
    input logic memtoreg,
    input logic branch,
    input logic zero,
    input logic overflow,
    input logic trap_ovf
  );
    logic             exc;
    logic [CTL_W-1:0] ctl;
    exc               = overflow & trap_ovf;
    ctl               = '0;
    ctl[CTL_MEMREAD]  = memread & ~exc;
    ctl[CTL_MEMWRITE] = memwrite & ~exc;
    ctl[CTL_REGWRITE] = regwrite & ~exc;
    ctl[CTL_MEMTOREG] = memtoreg;
    ctl[CTL_BRTAKEN]  = branch & zero & ~exc;
    ctl[CTL_EXC_OVF]  = exc;
    return ctl;
  endfunction

endpackage

// File: rtl/ex_mem_stage_skid.sv
// Two-entry skid register: main entry drives the outputs, skid entry absorbs
// the one beat that arrives while main is stalled; ready is purely registered.
module pipe_skid_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         main_v;
  logic         skid_v;
  logic [W-1:0] main_d;
  logic [W-1:0] skid_d;
  logic         accept;
  logic         main_free;
  logic         main_load;
  logic         skid_load;

  assign accept    = in_valid & ~skid_v;
  assign main_free = ~main_v | (main_v & out_ready);
  assign main_load = ~flush & main_free & (skid_v | accept);
  assign skid_load = ~flush & ~main_free & accept;

  assign in_ready  = ~skid_v;
  assign out_valid = main_v;
  assign out_data  = main_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      main_v <= 1'b0;
      skid_v <= 1'b0;
    end else if (flush) begin
      main_v <= 1'b0;
      skid_v <= 1'b0;
    end else if (main_free) begin
      main_v <= skid_v | accept;
      skid_v <= 1'b0;
    end else if (accept) begin
      skid_v <= 1'b1;
    end
  end

  // Skid always wins the refill so a newer beat can never overtake it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      main_d <= '0;
      skid_d <= '0;
    end else begin
      if (main_load) main_d <= skid_v ? skid_d : in_data;
      if (skid_load) skid_d <= in_data;
    end
  end

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline boundary: packs the execute results, applies the overflow
// and branch capture transform, and buffers beats through a 2-entry skid.
module ex_mem_stage
  import ex_mem_stage_pkg::*;
#(
  parameter int N  = 32,
  parameter int RW = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in_alu_out,
  input  logic          in_zero,
  input  logic          in_overflow,
  input  logic          in_trap_ovf,
  input  logic [N-1:0]  in_store_data,
  input  logic [RW-1:0] in_rd,
  input  logic [N-1:0]  in_pc,
  input  logic          in_memread,
  input  logic          in_memwrite,
  input  logic          in_regwrite,
  input  logic          in_memtoreg,
  input  logic          in_branch,
  input  logic          flush,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  out_alu_out,
  output logic [N-1:0]  out_store_data,
  output logic [N-1:0]  out_pc,
  output logic [RW-1:0] out_rd,
  output logic          out_memread,
  output logic          out_memwrite,
  output logic          out_regwrite,
  output logic          out_memtoreg,
  output logic          out_branch_taken,
  output logic          out_exc_ovf
);

  localparam int OFF_RD    = CTL_W;
  localparam int OFF_PC    = OFF_RD + RW;
  localparam int OFF_STORE = OFF_PC + N;
  localparam int OFF_ALU   = OFF_STORE + N;
  localparam int W         = OFF_ALU + N;

  logic [CTL_W-1:0] in_ctl;
  logic [W-1:0]     in_data;
  logic [W-1:0]     out_data;

  assign in_ctl  = capture_ctl(in_memread, in_memwrite, in_regwrite, in_memtoreg,
                               in_branch, in_zero, in_overflow, in_trap_ovf);
  assign in_data = {in_alu_out, in_store_data, in_pc, in_rd, in_ctl};

  pipe_skid_reg #(.W(W)) u_skid (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  assign out_alu_out      = out_data[OFF_ALU +: N];
  assign out_store_data   = out_data[OFF_STORE +: N];
  assign out_pc           = out_data[OFF_PC +: N];
  assign out_rd           = out_data[OFF_RD +: RW];
  assign out_memread      = out_data[CTL_MEMREAD];
  assign out_memwrite     = out_data[CTL_MEMWRITE];
  assign out_regwrite     = out_data[CTL_REGWRITE];
  assign out_memtoreg     = out_data[CTL_MEMTOREG];
  assign out_branch_taken = out_data[CTL_BRTAKEN];
  assign out_exc_ovf      = out_data[CTL_EXC_OVF];

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed self-checking bench for ex_mem_stage: streaming, stall/skid,
// overflow trap, branch resolve, flush and asynchronous reset.
module tb_ex_mem_stage;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_alu_out;
  logic        in_zero;
  logic        in_overflow;
  logic        in_trap_ovf;
  logic [31:0] in_store_data;
  logic [4:0]  in_rd;
  logic [31:0] in_pc;
  logic        in_memread;
  logic        in_memwrite;
  logic        in_regwrite;
  logic        in_memtoreg;
  logic        in_branch;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_alu_out;
  logic [31:0] out_store_data;
  logic [31:0] out_pc;
  logic [4:0]  out_rd;
  logic        out_memread;
  logic        out_memwrite;
  logic        out_regwrite;
  logic        out_memtoreg;
  logic        out_branch_taken;
  logic        out_exc_ovf;

  int checks;
  int failures;

  ex_mem_stage #(.N(32), .RW(5)) dut (
    .clk              (clk),
    .reset            (reset),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .in_alu_out       (in_alu_out),
    .in_zero          (in_zero),
    .in_overflow      (in_overflow),
    .in_trap_ovf      (in_trap_ovf),
    .in_store_data    (in_store_data),
    .in_rd            (in_rd),
    .in_pc            (in_pc),
    .in_memread       (in_memread),
    .in_memwrite      (in_memwrite),
    .in_regwrite      (in_regwrite),
    .in_memtoreg      (in_memtoreg),
    .in_branch        (in_branch),
    .flush            (flush),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_alu_out      (out_alu_out),
    .out_store_data   (out_store_data),
    .out_pc           (out_pc),
    .out_rd           (out_rd),
    .out_memread      (out_memread),
    .out_memwrite     (out_memwrite),
    .out_regwrite     (out_regwrite),
    .out_memtoreg     (out_memtoreg),
    .out_branch_taken (out_branch_taken),
    .out_exc_ovf      (out_exc_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Plain beat: store_data/pc/rd derived from alu so payload order is traceable.
  task automatic load_beat(input logic [31:0] alu);
    in_valid      = 1'b1;
    in_alu_out    = alu;
    in_store_data = alu ^ 32'hFFFF_0000;
    in_pc         = alu << 2;
    in_rd         = alu[4:0];
    in_zero       = 1'b0;
    in_overflow   = 1'b0;
    in_trap_ovf   = 1'b0;
    in_memread    = 1'b0;
    in_memwrite   = 1'b0;
    in_regwrite   = 1'b0;
    in_memtoreg   = 1'b0;
    in_branch     = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_out_valid got=%0b exp=0", out_valid);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_in_ready got=%0b exp=1", in_ready);
    end
    checks++;
    if ({out_alu_out, out_store_data, out_pc, out_rd, out_regwrite, out_exc_ovf} !== '0) begin
      failures++;
      $display("FAIL reset_payload got alu=%h pc=%h exp=0", out_alu_out, out_pc);
    end
    #12;
    reset = 1'b1;
    step();
  endtask

  task automatic test_streaming();
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      load_beat(i);
      step();
      checks++;
      if (out_valid !== 1'b1 || out_alu_out !== 32'(i) || out_pc !== 32'(i * 4)) begin
        failures++;
        $display("FAIL stream_beat%0d got v=%0b alu=%h pc=%h exp v=1 alu=%h", i, out_valid, out_alu_out, out_pc, i);
      end
      checks++;
      if (in_ready !== 1'b1) begin
        failures++;
        $display("FAIL stream_in_ready%0d got=%0b exp=1", i, in_ready);
      end
    end
    in_valid = 1'b0;
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL stream_empty got=%0b exp=0", out_valid);
    end
  endtask

  task automatic test_stall();
    out_ready = 1'b0;
    load_beat(32'hA);
    step();
    checks++;
    if (out_valid !== 1'b1 || out_alu_out !== 32'hA || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL stall_a_main got v=%0b alu=%h rdy=%0b exp v=1 alu=a rdy=1", out_valid, out_alu_out, in_ready);
    end
    load_beat(32'hB);
    step();
    checks++;
    if (in_ready !== 1'b0 || out_alu_out !== 32'hA) begin
      failures++;
      $display("FAIL stall_b_skid got rdy=%0b alu=%h exp rdy=0 alu=a", in_ready, out_alu_out);
    end
    load_beat(32'hC);
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (out_valid !== 1'b1 || out_alu_out !== 32'hA || out_store_data !== (32'hA ^ 32'hFFFF_0000)
          || out_rd !== 5'hA || in_ready !== 1'b0) begin
        failures++;
        $display("FAIL stall_hold%0d got v=%0b alu=%h sd=%h rd=%h rdy=%0b exp alu=a rdy=0", i, out_valid, out_alu_out, out_store_data, out_rd, in_ready);
      end
    end
    out_ready = 1'b1;
    step();
    checks++;
    if (out_valid !== 1'b1 || out_alu_out !== 32'hB || out_pc !== 32'h2C || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL stall_drain_b got v=%0b alu=%h pc=%h rdy=%0b exp alu=b pc=2c rdy=1", out_valid, out_alu_out, out_pc, in_ready);
    end
    step();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_alu_out !== 32'hC) begin
      failures++;
      $display("FAIL stall_drain_c got v=%0b alu=%h exp v=1 alu=c", out_valid, out_alu_out);
    end
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL stall_empty got=%0b exp=0", out_valid);
    end
  endtask

  task automatic test_overflow_trap();
    out_ready = 1'b1;
    load_beat(32'h8000_0000);
    in_overflow = 1'b1;
    in_trap_ovf = 1'b1;
    in_regwrite = 1'b1;
    in_memwrite = 1'b1;
    in_memread  = 1'b1;
    in_branch   = 1'b1;
    in_zero     = 1'b1;
    in_rd       = 5'd9;
    in_pc       = 32'h0040_0010;
    step();
    in_valid = 1'b0;
    checks++;
    if (out_exc_ovf !== 1'b1 || out_regwrite !== 1'b0 || out_memwrite !== 1'b0
        || out_memread !== 1'b0 || out_branch_taken !== 1'b0) begin
      failures++;
      $display("FAIL ovf_trap_ctl got exc=%0b rw=%0b mw=%0b mr=%0b bt=%0b exp 1,0,0,0,0", out_exc_ovf, out_regwrite, out_memwrite, out_memread, out_branch_taken);
    end
    checks++;
    if (out_alu_out !== 32'h8000_0000 || out_rd !== 5'd9 || out_pc !== 32'h0040_0010) begin
      failures++;
      $display("FAIL ovf_trap_keep got alu=%h rd=%0d pc=%h exp 80000000 9 00400010", out_alu_out, out_rd, out_pc);
    end
    step();
  endtask

  task automatic test_overflow_notrap();
    out_ready = 1'b1;
    load_beat(32'h7FFF_FFFF);
    in_overflow = 1'b1;
    in_regwrite = 1'b1;
    in_memwrite = 1'b1;
    in_memtoreg = 1'b1;
    step();
    in_valid = 1'b0;
    checks++;
    if (out_exc_ovf !== 1'b0 || out_regwrite !== 1'b1 || out_memwrite !== 1'b1 || out_memtoreg !== 1'b1) begin
      failures++;
      $display("FAIL ovf_notrap got exc=%0b rw=%0b mw=%0b mtr=%0b exp 0,1,1,1", out_exc_ovf, out_regwrite, out_memwrite, out_memtoreg);
    end
    step();
  endtask

  task automatic test_branch();
    out_ready = 1'b1;
    load_beat(32'h10);
    in_branch = 1'b1;
    in_zero   = 1'b1;
    step();
    checks++;
    if (out_valid !== 1'b1 || out_branch_taken !== 1'b1) begin
      failures++;
      $display("FAIL branch_taken got v=%0b bt=%0b exp 1,1", out_valid, out_branch_taken);
    end
    load_beat(32'h14);
    in_branch = 1'b1;
    in_zero   = 1'b0;
    step();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_branch_taken !== 1'b0 || out_alu_out !== 32'h14) begin
      failures++;
      $display("FAIL branch_not_taken got v=%0b bt=%0b alu=%h exp 1,0,14", out_valid, out_branch_taken, out_alu_out);
    end
    step();
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    load_beat(32'h21);
    step();
    load_beat(32'h22);
    step();
    load_beat(32'h23);
    flush = 1'b1;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL flush_state got v=%0b rdy=%0b exp v=0 rdy=1", out_valid, in_ready);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (out_valid !== 1'b0) begin
        failures++;
        $display("FAIL flush_ghost%0d got v=%0b alu=%h exp v=0", i, out_valid, out_alu_out);
      end
    end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    load_beat(32'h55);
    in_regwrite = 1'b1;
    step();
    load_beat(32'h66);
    step();
    in_valid = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_alu_out !== 32'h0 || out_pc !== 32'h0 || out_regwrite !== 1'b0) begin
      failures++;
      $display("FAIL async_reset got v=%0b alu=%h pc=%h rw=%0b exp all 0", out_valid, out_alu_out, out_pc, out_regwrite);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL async_reset_ready got=%0b exp=1", in_ready);
    end
    #3;
    reset = 1'b1;
    out_ready = 1'b1;
    step();
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL async_reset_lost got v=%0b exp 0", out_valid);
    end
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    flush     = 1'b0;
    out_ready = 1'b0;
    load_beat(32'h0);
    in_valid  = 1'b0;
    test_reset();
    test_streaming();
    test_stall();
    test_overflow_trap();
    test_overflow_notrap();
    test_branch();
    test_flush();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
